// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the MAK-8 fetch stage.
//
// Produces the fetch PC. On every edge it applies the single highest-priority request and drops
// the rest. Supported requests are stall, absolute jump, relative branch, and call/return through
// a small hardware return stack.
//
// Optional feature: define PC_SEQ_IRQ_EN to add the interrupt vector path. This adds the
// irq_req/irq_ack ports and an internal irq_busy flag.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   stall        hold all state this cycle, drop every request
//   jump         pc <= target
//   branch       pc <= pc + 1 + sext(offset)
//   call         push pc+1, pc <= target
//   ret          pop, pc <= popped address
//   target       absolute destination for jump/call
//   offset       signed branch offset
//   pc_out       current PC (registered)
//   stack_empty  no return addresses held
//   stack_full   STACK_DEPTH return addresses held
//   stack_err    sticky overflow/underflow flag, cleared only by reset
//   irq_req      level interrupt request            (PC_SEQ_IRQ_EN only)
//   irq_ack      one-cycle interrupt acceptance pulse (PC_SEQ_IRQ_EN only)
module pc_sequencer #(
    parameter int unsigned        ADDR_W      = 16,
    parameter logic [ADDR_W-1:0]  RESET_VEC   = ADDR_W'(0),
    parameter int unsigned        OFF_W       = 8,
    parameter int unsigned        STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0]  IRQ_VEC     = ADDR_W'(8)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump,
    input  logic              branch,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic [OFF_W-1:0]  offset,
`ifdef PC_SEQ_IRQ_EN
    input  logic              irq_req,
    output logic              irq_ack,
`endif
    output logic [ADDR_W-1:0] pc_out,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              stack_err
);

    // The pointer must be able to hold STACK_DEPTH itself (the "full" value).
    localparam int unsigned PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(STACK_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic              err_q, err_d;

    logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic              push_en;
    logic [ADDR_W-1:0] push_data;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] branch_pc;
    logic              is_empty, is_full;

    assign pc_inc    = pc_q + ADDR_W'(1);
    // The size cast on a signed operand sign-extends the offset to the PC width.
    assign branch_pc = pc_inc + ADDR_W'($signed(offset));
    assign is_empty  = (sp_q == '0);
    assign is_full   = (sp_q == SP_FULL);
    assign wr_idx    = IDX_W'(sp_q);
    assign rd_idx    = IDX_W'(sp_q - PTR_W'(1));

`ifdef PC_SEQ_IRQ_EN
    logic irq_busy_q, irq_busy_d;
    logic irq_ack_q, irq_ack_d;
    logic irq_take;

    // A full stack holds the interrupt off silently; no error is raised.
    assign irq_take = irq_req & ~irq_busy_q & ~stall & ~is_full;
    assign irq_ack  = irq_ack_q;
`else
    logic [ADDR_W-1:0] unused_irq_vec;
    assign unused_irq_vec = IRQ_VEC;
`endif

    always_comb begin
        pc_d      = pc_q;
        sp_d      = sp_q;
        err_d     = err_q;
        push_en   = 1'b0;
        push_data = pc_inc;
`ifdef PC_SEQ_IRQ_EN
        irq_busy_d = irq_busy_q;
        irq_ack_d  = 1'b0;
`endif
        if (!stall) begin
`ifdef PC_SEQ_IRQ_EN
            if (irq_take) begin
                // Return to the instruction that was about to execute, not the one after it.
                push_en    = 1'b1;
                push_data  = pc_q;
                sp_d       = sp_q + PTR_W'(1);
                pc_d       = IRQ_VEC;
                irq_busy_d = 1'b1;
                irq_ack_d  = 1'b1;
            end else
`endif
            if (ret) begin
                if (!is_empty) begin
                    sp_d = sp_q - PTR_W'(1);
                    pc_d = stack_mem[rd_idx];
`ifdef PC_SEQ_IRQ_EN
                    irq_busy_d = 1'b0;
`endif
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (call) begin
                if (!is_full) begin
                    push_en = 1'b1;
                    sp_d    = sp_q + PTR_W'(1);
                    pc_d    = target;
                end else begin
                    err_d = 1'b1;
                    pc_d  = pc_inc;
                end
            end else if (jump) begin
                pc_d = target;
            end else if (branch) begin
                pc_d = branch_pc;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            err_q <= 1'b0;
`ifdef PC_SEQ_IRQ_EN
            irq_busy_q <= 1'b0;
            irq_ack_q  <= 1'b0;
`endif
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
`ifdef PC_SEQ_IRQ_EN
            irq_busy_q <= irq_busy_d;
            irq_ack_q  <= irq_ack_d;
`endif
        end
    end

    // Stack storage needs no reset; only the pointer defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push_en) begin
            stack_mem[wr_idx] <= push_data;
        end
    end

    assign pc_out      = pc_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer. It drives a default 16-bit instance and an 8-bit instance
// from shared controls. The 8-bit instance covers wrap-around cases.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0, jump = 1'b0, branch = 1'b0, call = 1'b0, ret = 1'b0;
    logic [15:0] target = '0;
    logic [7:0]  offset = '0;
    logic [15:0] pc_out;
    logic        stack_empty, stack_full, stack_err;
    logic [7:0]  pc_out8;
    logic        empty8, full8, err8;
    logic        irq_req = 1'b0;
    logic        irq_ack, irq_ack8;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump        (jump),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .target      (target),
        .offset      (offset),
`ifdef PC_SEQ_IRQ_EN
        .irq_req     (irq_req),
        .irq_ack     (irq_ack),
`endif
        .pc_out      (pc_out),
        .stack_empty (stack_empty),
        .stack_full  (stack_full),
        .stack_err   (stack_err)
    );

    pc_sequencer #(.ADDR_W(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jump        (jump),
        .branch      (branch),
        .call        (call),
        .ret         (ret),
        .target      (target[7:0]),
        .offset      (offset),
`ifdef PC_SEQ_IRQ_EN
        .irq_req     (irq_req),
        .irq_ack     (irq_ack8),
`endif
        .pc_out      (pc_out8),
        .stack_empty (empty8),
        .stack_full  (full8),
        .stack_err   (err8)
    );

`ifndef PC_SEQ_IRQ_EN
    assign irq_ack  = 1'b0;
    assign irq_ack8 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_req();
        stall = 1'b0; jump = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; irq_req = 1'b0;
    endtask

    task automatic do_reset();
        clear_req();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // 1: reset and increment
        #1;
        step();
        step();
        check("rst_pc", pc_out, 32'h0000);
        check("rst_empty", stack_empty, 1);
        check("rst_full", stack_full, 0);
        check("rst_err", stack_err, 0);
        rst = 1'b0;
        step(); check("inc1", pc_out, 32'h0001);
        step(); check("inc2", pc_out, 32'h0002);

        // 2: wrap and branch (8-bit instance), 16-bit branch alongside
        jump = 1'b1; target = 16'h00FE; step();
        check("w8_load", pc_out8, 32'hFE);
        jump = 1'b0;
        step(); check("w8_ff", pc_out8, 32'hFF);
        step(); check("w8_00", pc_out8, 32'h00);
        step(); check("w8_01", pc_out8, 32'h01);
        jump = 1'b1; target = 16'h0010; step(); jump = 1'b0;
        branch = 1'b1; offset = 8'hFC; step(); branch = 1'b0;
        check("br8_neg", pc_out8, 32'h0D);
        check("br16_neg", pc_out, 32'h000D);
        jump = 1'b1; target = 16'h00F0; step(); jump = 1'b0;
        branch = 1'b1; offset = 8'h7F; step(); branch = 1'b0;
        check("br8_wrap", pc_out8, 32'h70);
        check("br16_pos", pc_out, 32'h0170);

        // 3: nested call/return, overflow
        do_reset();
        jump = 1'b1; target = 16'h0005; step(); jump = 1'b0;
        call = 1'b1; target = 16'h0100; step(); call = 1'b0;
        check("call1", pc_out, 32'h0100);
        check("call1_empty", stack_empty, 0);
        jump = 1'b1; target = 16'h0102; step(); jump = 1'b0;
        call = 1'b1; target = 16'h0200; step(); call = 1'b0;
        check("call2", pc_out, 32'h0200);
        ret = 1'b1; step(); check("ret2", pc_out, 32'h0103);
        step(); ret = 1'b0; check("ret1", pc_out, 32'h0006);
        check("ret_empty", stack_empty, 1);
        call = 1'b1; target = 16'h0300;
        for (int i = 0; i < 4; i++) step();
        check("fill_full", stack_full, 1);
        check("fill_err", stack_err, 0);
        step(); call = 1'b0;
        check("ovf_pc", pc_out, 32'h0301);
        check("ovf_err", stack_err, 1);
        check("ovf_full", stack_full, 1);

        // 4: stall drops a concurrent jump
        do_reset();
        stall = 1'b1; jump = 1'b1; target = 16'hABCD;
        step(); check("stall1", pc_out, 32'h0000);
        step(); check("stall2", pc_out, 32'h0000);
        step(); check("stall3", pc_out, 32'h0000);
        stall = 1'b0; jump = 1'b0;
        step(); check("unstall", pc_out, 32'h0001);

        // 5: underflow, call+ret, mid-run reset
        do_reset();
        jump = 1'b1; target = 16'h0020; step(); jump = 1'b0;
        ret = 1'b1; step(); ret = 1'b0;
        check("unf_pc", pc_out, 32'h0021);
        check("unf_err", stack_err, 1);
        step(); check("err_sticky", stack_err, 1);
        call = 1'b1; target = 16'h0050; step();
        check("c1_pc", pc_out, 32'h0050);
        ret = 1'b1; target = 16'h0070; step(); call = 1'b0; ret = 1'b0;
        check("cr_pc", pc_out, 32'h0023);
        check("cr_empty", stack_empty, 1);
        call = 1'b1; target = 16'h0080; step(); call = 1'b0;
        check("pre_rst_empty", stack_empty, 0);
        rst = 1'b1; jump = 1'b1; step(); rst = 1'b0; jump = 1'b0;
        check("mid_rst_pc", pc_out, 32'h0000);
        check("mid_rst_empty", stack_empty, 1);
        check("mid_rst_err", stack_err, 0);
        check("mid_rst_full", stack_full, 0);

`ifdef PC_SEQ_IRQ_EN
        // 6: interrupt entry, hold-off while busy, return
        do_reset();
        check("irq_rst_ack", irq_ack, 0);
        jump = 1'b1; target = 16'h0040; step(); jump = 1'b0;
        irq_req = 1'b1; step();
        check("irq_pc", pc_out, 32'h0008);
        check("irq_ack1", irq_ack, 1);
        step();
        check("irq_held_pc", pc_out, 32'h0009);
        check("irq_ack0", irq_ack, 0);
        irq_req = 1'b0; ret = 1'b1; step(); ret = 1'b0;
        check("irq_ret", pc_out, 32'h0040);
        irq_req = 1'b1; step(); irq_req = 1'b0;
        check("irq_again_pc", pc_out, 32'h0008);
        check("irq_again_ack", irq_ack, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
